// File: rtl/optical_ctrl_pkg.sv
// optical_ctrl_pkg: types and constants shared by the 4x4 optical switch initiator and controller
package optical_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        SETTLE,
        DONE
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_PERM    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic P_BAR   = 1'b0;
    localparam logic P_CROSS = 1'b1;

endpackage

// File: rtl/optical_perm_check.sv
// optical_perm_check: flags whether four packed 2-bit destinations form a permutation
module optical_perm_check (
    input  logic [7:0] i_perm,
    output logic       o_is_perm
);

    logic [1:0] d0, d1, d2, d3;

    assign d0 = i_perm[1:0];
    assign d1 = i_perm[3:2];
    assign d2 = i_perm[5:4];
    assign d3 = i_perm[7:6];

    assign o_is_perm = (d0 != d1) && (d0 != d2) && (d0 != d3) &&
                       (d1 != d2) && (d1 != d3) && (d2 != d3);

endmodule

// File: rtl/optical_4x4_cfg_initiator.sv
// optical_4x4_cfg_initiator: validates a permutation request, obtains the controller grant,
// drives the switch settings and waits out optical settling before reporting completion.
module optical_4x4_cfg_initiator
    import optical_ctrl_pkg::*;
#(
    parameter int P_SETTLE_CYCLES = 16,
    parameter int P_GRANT_TIMEOUT = 8,
    parameter int P_CNT_W         = 8,
    parameter int P_SKIP_SAME     = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_perm_req,
    input  logic       i_perm_valid,
    output logic       o_perm_ready,
    output logic [7:0] o_4x4_req,
    output logic       o_4x4_valid,
    input  logic [5:0] i_switch_grant,
    input  logic       i_grant_valid,
    output logic [5:0] o_switch_drv,
    output logic       o_drv_update,
    output logic       o_config_end,
    output logic       o_err,
    output logic [1:0] o_err_code,
    output logic       o_busy
);

    state_t             state_q, state_d;
    logic [7:0]         req_q, req_d;
    logic [7:0]         last_q, last_d;
    logic               last_v_q, last_v_d;
    logic [P_CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]         drv_q, drv_d;
    logic               upd_q, upd_d;
    logic [1:0]         code_q;
    logic               is_perm;
    logic               err;
    logic [1:0]         err_code;

    optical_perm_check u_perm_check (
        .i_perm   (req_q),
        .o_is_perm(is_perm)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            last_q   <= '0;
            last_v_q <= 1'b0;
            cnt_q    <= '0;
            drv_q    <= {6{P_BAR}};
            upd_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            last_q   <= last_d;
            last_v_q <= last_v_d;
            cnt_q    <= cnt_d;
            drv_q    <= drv_d;
            upd_q    <= upd_d;
            code_q   <= err ? err_code : code_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        last_d   = last_q;
        last_v_d = last_v_q;
        cnt_d    = cnt_q;
        drv_d    = drv_q;
        upd_d    = 1'b0;
        err      = 1'b0;
        err_code = ERR_NONE;
        case (state_q)
            IDLE: begin
                if (i_perm_valid) begin
                    req_d   = i_perm_req;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!is_perm) begin
                    err      = 1'b1;
                    err_code = ERR_PERM;
                    state_d  = IDLE;
                end else if (P_SKIP_SAME != 0 && last_v_q && req_q == last_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = P_CNT_W'(P_GRANT_TIMEOUT - 1);
                    state_d = REQ;
                end
            end
            REQ: begin
                // a grant arriving on the expiry cycle still wins
                if (i_grant_valid) begin
                    drv_d   = i_switch_grant;
                    upd_d   = 1'b1;
                    cnt_d   = P_CNT_W'(P_SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end else if (cnt_q == '0) begin
                    err      = 1'b1;
                    err_code = ERR_TIMEOUT;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = DONE;
                else cnt_d = cnt_q - 1'b1;
            end
            DONE: begin
                last_d   = req_q;
                last_v_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ready is gated by reset so every output reads 0 while reset is held
    assign o_perm_ready = i_rst && state_q == IDLE;
    assign o_4x4_req    = req_q;
    assign o_4x4_valid  = state_q == REQ;
    assign o_switch_drv = drv_q;
    assign o_drv_update = upd_q;
    assign o_config_end = state_q == DONE;
    assign o_err        = err;
    assign o_err_code   = err ? err_code : code_q;
    assign o_busy       = state_q != IDLE;

endmodule
